// File: rtl/anffl_tex_bilinear_filter_pkg.sv
// Shared texture-path types: RGBA8 texel, 2x2 quad positions and the default fraction width.
// Holds only types and constants.
package anffl_tex_bilinear_filter_pkg;

    localparam int FRAC_BITS_DEF = 8;

    localparam logic [1:0] QUAD_X0Y0 = 2'd0;
    localparam logic [1:0] QUAD_X1Y0 = 2'd1;
    localparam logic [1:0] QUAD_X0Y1 = 2'd2;
    localparam logic [1:0] QUAD_X1Y1 = 2'd3;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] a;
    } texel_t;

endpackage

// File: rtl/anffl_tex_bilinear_filter_if.sv
// Texel-in / filtered-result-out bundle of the bilinear filter stage.
// The slave modport is the filter; the master modport is its environment.
interface anffl_tex_bilinear_filter_if #(
    parameter int FRAC_BITS = anffl_tex_bilinear_filter_pkg::FRAC_BITS_DEF
);
    logic                 in_valid;
    logic                 in_ready;
    logic [7:0]           in_R;
    logic [7:0]           in_G;
    logic [7:0]           in_B;
    logic [7:0]           in_A;
    logic [1:0]           in_idx;
    logic [FRAC_BITS-1:0] in_fracU;
    logic [FRAC_BITS-1:0] in_fracV;
    logic                 in_nearest;
    logic                 out_valid;
    logic                 out_ready;
    logic [7:0]           out_R;
    logic [7:0]           out_G;
    logic [7:0]           out_B;
    logic [7:0]           out_A;
    logic                 err_seq;

    modport slave (
        input  in_valid, in_R, in_G, in_B, in_A, in_idx, in_fracU, in_fracV, in_nearest,
        input  out_ready,
        output in_ready, out_valid, out_R, out_G, out_B, out_A, err_seq
    );

    modport master (
        output in_valid, in_R, in_G, in_B, in_A, in_idx, in_fracU, in_fracV, in_nearest,
        output out_ready,
        input  in_ready, out_valid, out_R, out_G, out_B, out_A, err_seq
    );
endinterface

// File: rtl/anffl_tex_lerp_channel.sv
// One colour channel of the bilinear filter: multiply-accumulate of texel*weight plus round-half-up.
// o_result is combinational on the current texel so the parent can register it on the last texel; no flow control here.
module anffl_tex_lerp_channel #(
    parameter int FRAC_BITS = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_load,
    input  logic                   i_add,
    input  logic [7:0]             i_texel,
    input  logic [2*FRAC_BITS:0]   i_weight,
    output logic [7:0]             o_result
);
    localparam int ACC_W = 2*FRAC_BITS + 8;
    localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << (2*FRAC_BITS - 1);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_prod;
    logic [ACC_W-1:0] w_sum;
    logic [ACC_W-1:0] w_rnd;

    // Largest weight is S^2, so the product never needs more than ACC_W bits.
    assign w_prod   = ACC_W'(i_texel) * ACC_W'(i_weight);
    assign w_sum    = (i_load ? '0 : r_acc) + w_prod;
    assign w_rnd    = w_sum + HALF;
    assign o_result = 8'(w_rnd >> (2*FRAC_BITS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_load || i_add) begin
            r_acc <= w_sum;
        end
    end

endmodule

// File: rtl/anffl_tex_bilinear_filter.sv
// Bilinear (or nearest) texture filter: accumulates a 2x2 quad of RGBA8 texels into one weighted RGBA8 result.
// Result registered 1 cycle after the last texel; in_ready = !out_valid || out_ready, so a held result stalls input.
module anffl_tex_bilinear_filter
    import anffl_tex_bilinear_filter_pkg::*;
#(
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    anffl_tex_bilinear_filter_if.slave    bus
);
    localparam int W_W = 2*FRAC_BITS + 1;
    localparam logic [W_W-1:0] S = W_W'(1) << FRAC_BITS;

    logic [1:0]           r_exp;
    logic [FRAC_BITS-1:0] r_fu;
    logic [FRAC_BITS-1:0] r_fv;
    texel_t               r_out;
    logic                 r_out_valid;
    logic                 r_err;

    logic                 w_acc;
    logic                 w_start;
    logic                 w_cont;
    logic                 w_mis;
    logic                 w_near_done;
    logic                 w_done;
    logic [W_W-1:0]       w_fu;
    logic [W_W-1:0]       w_fv;
    logic [W_W-1:0]       w_fu_c;
    logic [W_W-1:0]       w_fv_c;
    logic [W_W-1:0]       w_wt;
    texel_t               w_tex;
    texel_t               w_res;

    assign bus.in_ready = !r_out_valid || bus.out_ready;
    assign w_acc        = bus.in_valid && bus.in_ready;

    // An idx-0 texel always opens a new quad, even when it arrives out of order.
    assign w_start      = w_acc && (bus.in_idx == QUAD_X0Y0);
    assign w_cont       = w_acc && (bus.in_idx != QUAD_X0Y0) && (bus.in_idx == r_exp);
    assign w_mis        = w_acc && (bus.in_idx != r_exp);
    assign w_near_done  = w_start && bus.in_nearest;
    assign w_done       = w_near_done || (w_cont && (bus.in_idx == QUAD_X1Y1));

    // The idx-0 weight uses the fractions arriving with it, before they are latched.
    assign w_fu   = W_W'((bus.in_idx == QUAD_X0Y0) ? bus.in_fracU : r_fu);
    assign w_fv   = W_W'((bus.in_idx == QUAD_X0Y0) ? bus.in_fracV : r_fv);
    assign w_fu_c = S - w_fu;
    assign w_fv_c = S - w_fv;

    always_comb begin
        w_wt = '0;
        case (bus.in_idx)
            QUAD_X0Y0: w_wt = w_fu_c * w_fv_c;
            QUAD_X1Y0: w_wt = w_fu   * w_fv_c;
            QUAD_X0Y1: w_wt = w_fu_c * w_fv;
            QUAD_X1Y1: w_wt = w_fu   * w_fv;
            default:   w_wt = '0;
        endcase
    end

    assign w_tex = '{r: bus.in_R, g: bus.in_G, b: bus.in_B, a: bus.in_A};

    anffl_tex_lerp_channel #(.FRAC_BITS(FRAC_BITS)) u_lerp_r (
        .clk(clk), .rst_n(rst_n), .i_load(w_start), .i_add(w_cont),
        .i_texel(w_tex.r), .i_weight(w_wt), .o_result(w_res.r)
    );
    anffl_tex_lerp_channel #(.FRAC_BITS(FRAC_BITS)) u_lerp_g (
        .clk(clk), .rst_n(rst_n), .i_load(w_start), .i_add(w_cont),
        .i_texel(w_tex.g), .i_weight(w_wt), .o_result(w_res.g)
    );
    anffl_tex_lerp_channel #(.FRAC_BITS(FRAC_BITS)) u_lerp_b (
        .clk(clk), .rst_n(rst_n), .i_load(w_start), .i_add(w_cont),
        .i_texel(w_tex.b), .i_weight(w_wt), .o_result(w_res.b)
    );
    anffl_tex_lerp_channel #(.FRAC_BITS(FRAC_BITS)) u_lerp_a (
        .clk(clk), .rst_n(rst_n), .i_load(w_start), .i_add(w_cont),
        .i_texel(w_tex.a), .i_weight(w_wt), .o_result(w_res.a)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exp       <= QUAD_X0Y0;
            r_fu        <= '0;
            r_fv        <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_mis;
            if (w_start) begin
                r_fu  <= bus.in_fracU;
                r_fv  <= bus.in_fracV;
                r_exp <= bus.in_nearest ? QUAD_X0Y0 : QUAD_X1Y0;
            end else if (w_cont) begin
                r_exp <= r_exp + 2'd1;
            end
            // A completing result overrides the clear from a same-cycle consume.
            if (w_done) begin
                r_out_valid <= 1'b1;
                r_out       <= w_near_done ? w_tex : w_res;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_R     = r_out.r;
    assign bus.out_G     = r_out.g;
    assign bus.out_B     = r_out.b;
    assign bus.out_A     = r_out.a;
    assign bus.err_seq   = r_err;

endmodule

// File: tb/tb_anffl_tex_bilinear_filter.sv
// Bench for anffl_tex_bilinear_filter: directed quads plus randomized quads against an arithmetic reference model.
module tb_anffl_tex_bilinear_filter;
    localparam int FB = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    anffl_tex_bilinear_filter_if #(.FRAC_BITS(FB)) ifc();
    anffl_tex_bilinear_filter #(.FRAC_BITS(FB)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

    int n_checks = 0;
    int n_fail   = 0;
    int err_cnt  = 0;
    int exp_err  = 0;
    bit rand_bp  = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] out_rgba;
    assign out_rgba = {ifc.out_R, ifc.out_G, ifc.out_B, ifc.out_A};

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference: each channel = round_half_up(sum_k t_k * w_k / S^2), weights from the bilinear formula.
    function automatic logic [31:0] model_bilin(input logic [31:0] t0, t1, t2, t3,
                                                input logic [FB-1:0] fu_in, fv_in);
        longint s, fu, fv, sum;
        longint w[4];
        logic [31:0] tt[4];
        logic [31:0] r;
        s = longint'(1) << FB;
        fu = longint'(fu_in);
        fv = longint'(fv_in);
        w[0] = (s - fu) * (s - fv);
        w[1] = fu * (s - fv);
        w[2] = (s - fu) * fv;
        w[3] = fu * fv;
        tt[0] = t0; tt[1] = t1; tt[2] = t2; tt[3] = t3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            sum = 0;
            for (int k = 0; k < 4; k++) sum += longint'(tt[k][8*c +: 8]) * w[k];
            r[8*c +: 8] = 8'((sum + s*s/2) >> (2*FB));
        end
        return r;
    endfunction

    function automatic logic [31:0] rtex(input logic [7:0] rch);
        logic [31:0] x;
        x = $urandom();
        return {rch, x[23:0]};
    endfunction

    function automatic logic [FB-1:0] rfrac();
        logic [31:0] x;
        x = $urandom();
        return x[FB-1:0];
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_texel(input logic [1:0] idx, input logic [31:0] tex,
                              input logic [FB-1:0] fu, input logic [FB-1:0] fv,
                              input logic nr, output int waited);
        bit hs;
        bit timed_out;
        timed_out = 1'b0;
        ifc.in_valid   = 1'b1;
        ifc.in_idx     = idx;
        {ifc.in_R, ifc.in_G, ifc.in_B, ifc.in_A} = tex;
        ifc.in_fracU   = fu;
        ifc.in_fracV   = fv;
        ifc.in_nearest = nr;
        waited = 0;
        forever begin
            if (rand_bp) ifc.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            hs = ifc.in_ready;
            @(posedge clk);
            @(negedge clk);
            if (hs) break;
            waited++;
            if (waited >= 200) begin
                timed_out = 1'b1;
                check_eq("hs_timeout", timed_out, 0);
                break;
            end
        end
        ifc.in_valid   = 1'b0;
        ifc.in_nearest = 1'b0;
    endtask

    task automatic send_quad(input logic [31:0] t0, t1, t2, t3, input logic [FB-1:0] fu, fv);
        int w;
        send_texel(2'd0, t0, fu, fv, 1'b0, w);
        send_texel(2'd1, t1, rfrac(), rfrac(), 1'b0, w);
        send_texel(2'd2, t2, rfrac(), rfrac(), 1'b0, w);
        exp_q.push_back(model_bilin(t0, t1, t2, t3, fu, fv));
        send_texel(2'd3, t3, rfrac(), rfrac(), 1'b0, w);
    endtask

    task automatic drain();
        ifc.out_ready = 1'b1;
        @(negedge clk);
        ifc.out_ready = 1'b0;
        #1;
        check_eq("drain_valid_clr", ifc.out_valid, 0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        ifc.in_valid = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        check_eq("rst_out_valid", ifc.out_valid, 0);
        check_eq("rst_out_rgba", out_rgba, 0);
        check_eq("rst_err_seq", ifc.err_seq, 0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Scoreboard: every consumed result must match the oldest predicted one.
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (ifc.err_seq) err_cnt++;
            if (ifc.out_valid && ifc.out_ready) begin
                if (exp_q.size() == 0) check_eq("unexpected_out", ifc.out_valid, 0);
                else check_eq("out_rgba", out_rgba, exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [31:0] q[4];
        logic [FB-1:0] fu, fv;
        ifc.in_valid = 1'b0; ifc.in_idx = '0; ifc.in_nearest = 1'b0;
        ifc.in_R = '0; ifc.in_G = '0; ifc.in_B = '0; ifc.in_A = '0;
        ifc.in_fracU = '0; ifc.in_fracV = '0; ifc.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_out_valid", ifc.out_valid, 0);
        check_eq("reset_out_rgba", out_rgba, 0);
        check_eq("reset_err_seq", ifc.err_seq, 0);
        check_eq("reset_in_ready", ifc.in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // fu=fv=0 selects texel 0; result held until consumed
        send_quad(rtex(8'd10), rtex(8'd20), rtex(8'd30), rtex(8'd40), 8'd0, 8'd0);
        check_eq("bl00_valid", ifc.out_valid, 1);
        check_eq("bl00_R", ifc.out_R, 10);
        repeat (3) @(negedge clk);
        check_eq("hold_valid", ifc.out_valid, 1);
        check_eq("hold_R", ifc.out_R, 10);
        check_eq("hold_in_ready", ifc.in_ready, 0);
        drain();

        send_quad(rtex(8'd10), rtex(8'd20), rtex(8'd30), rtex(8'd40), 8'd128, 8'd0);
        check_eq("bl_half_u_R", ifc.out_R, 15);
        drain();
        send_quad(rtex(8'd10), rtex(8'd20), rtex(8'd30), rtex(8'd40), 8'd128, 8'd128);
        check_eq("bl_half_uv_R", ifc.out_R, 25);
        drain();
        send_quad(32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff, 8'd255, 8'd255);
        check_eq("bl_max_rgba", out_rgba, 32'hffffffff);
        drain();

        // nearest: single texel, then a normal quad must start cleanly at idx 0
        exp_q.push_back(32'h01020304);
        send_texel(2'd0, 32'h01020304, rfrac(), rfrac(), 1'b1, w);
        check_eq("near_valid", ifc.out_valid, 1);
        check_eq("near_rgba", out_rgba, 32'h01020304);
        drain();
        send_quad(rtex(8'd77), rtex(8'd5), rtex(8'd200), rtex(8'd99), rfrac(), rfrac());
        drain();
        check_eq("near_no_err", err_cnt, exp_err);

        // backpressure then same-cycle consume + accept
        send_quad(rtex(8'd1), rtex(8'd2), rtex(8'd3), rtex(8'd4), rfrac(), rfrac());
        #1;
        check_eq("bp_in_ready", ifc.in_ready, 0);
        for (int k = 0; k < 4; k++) q[k] = $urandom();
        fu = rfrac(); fv = rfrac();
        ifc.out_ready = 1'b1;
        send_texel(2'd0, q[0], fu, fv, 1'b0, w);
        check_eq("bp_same_cycle", w, 0);
        check_eq("bp_old_consumed", ifc.out_valid, 0);
        send_texel(2'd1, q[1], rfrac(), rfrac(), 1'b0, w);
        send_texel(2'd2, q[2], rfrac(), rfrac(), 1'b0, w);
        exp_q.push_back(model_bilin(q[0], q[1], q[2], q[3], fu, fv));
        send_texel(2'd3, q[3], rfrac(), rfrac(), 1'b0, w);
        repeat (2) @(negedge clk);
        check_eq("bp_queue_empty", exp_q.size(), 0);

        // sequence error on a non-zero index: texel dropped
        for (int k = 0; k < 4; k++) q[k] = $urandom();
        fu = rfrac(); fv = rfrac();
        send_texel(2'd0, q[0], fu, fv, 1'b0, w);
        send_texel(2'd1, q[1], rfrac(), rfrac(), 1'b0, w);
        send_texel(2'd3, $urandom(), rfrac(), rfrac(), 1'b0, w);
        exp_err++;
        check_eq("seq_err_pulse", ifc.err_seq, 1);
        send_texel(2'd2, q[2], rfrac(), rfrac(), 1'b0, w);
        check_eq("seq_err_one_cycle", ifc.err_seq, 0);
        exp_q.push_back(model_bilin(q[0], q[1], q[2], q[3], fu, fv));
        send_texel(2'd3, q[3], rfrac(), rfrac(), 1'b0, w);

        // unexpected idx 0 restarts the quad with the new fractions
        send_texel(2'd0, $urandom(), rfrac(), rfrac(), 1'b0, w);
        send_texel(2'd1, $urandom(), rfrac(), rfrac(), 1'b0, w);
        for (int k = 0; k < 4; k++) q[k] = $urandom();
        fu = rfrac(); fv = rfrac();
        send_texel(2'd0, q[0], fu, fv, 1'b0, w);
        exp_err++;
        check_eq("restart_err_pulse", ifc.err_seq, 1);
        send_texel(2'd1, q[1], rfrac(), rfrac(), 1'b0, w);
        send_texel(2'd2, q[2], rfrac(), rfrac(), 1'b0, w);
        exp_q.push_back(model_bilin(q[0], q[1], q[2], q[3], fu, fv));
        send_texel(2'd3, q[3], rfrac(), rfrac(), 1'b0, w);
        repeat (3) @(negedge clk);
        check_eq("seq_err_count", err_cnt, exp_err);
        check_eq("seq_queue_empty", exp_q.size(), 0);

        // reset drops a pending result and a partial quad
        ifc.out_ready = 1'b0;
        send_quad(rtex(8'd50), rtex(8'd60), rtex(8'd70), rtex(8'd80), rfrac(), rfrac());
        do_reset();
        send_texel(2'd0, $urandom(), rfrac(), rfrac(), 1'b0, w);
        send_texel(2'd1, $urandom(), rfrac(), rfrac(), 1'b0, w);
        do_reset();
        send_quad(rtex(8'd10), rtex(8'd20), rtex(8'd30), rtex(8'd40), 8'd128, 8'd128);
        check_eq("post_rst_R", ifc.out_R, 25);
        drain();
        check_eq("post_rst_no_err", err_cnt, exp_err);

        // randomized quads / nearest texels with random consumer stalls
        rand_bp = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                q[0] = $urandom();
                exp_q.push_back(q[0]);
                send_texel(2'd0, q[0], rfrac(), rfrac(), 1'b1, w);
            end else begin
                for (int k = 0; k < 4; k++) q[k] = $urandom();
                send_quad(q[0], q[1], q[2], q[3], rfrac(), rfrac());
            end
        end
        rand_bp = 1'b0;
        ifc.out_ready = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("final_queue_empty", exp_q.size(), 0);
        check_eq("final_err_count", err_cnt, exp_err);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
